// File: rtl/ram_arbiter.sv
// Two-port (CPU = A, host = B) arbiter in front of a single-port 4096x16 RAM.
// Define ARB_RR_EN for round-robin tie-breaking; default build uses fixed A priority.
module ram_arbiter #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_load,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_last_b;   // most recent winner; also selects the port served in ACCESS
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_a_rvalid;
  logic            r_b_rvalid;
  logic [DW-1:0]   r_a_rdata;
  logic [DW-1:0]   r_b_rdata;
  logic            w_any;
  logic            w_win_b;

  // Winner selection for the request sampled this cycle
  always_comb begin
    w_any = a_req | b_req;
    if (a_req && b_req) begin
`ifdef ARB_RR_EN
      w_win_b = ~r_last_b;
`else
      w_win_b = 1'b0;
`endif
    end else begin
      w_win_b = b_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = S_IDLE;
    if (w_any) begin
      w_state_next = S_ACCESS;
    end
  end

  always_comb begin
    busy     = 1'b0;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    ram_load = 1'b0;
    if (r_state == S_ACCESS) begin
      busy     = 1'b1;
      a_gnt    = ~r_last_b;
      b_gnt    = r_last_b;
      ram_load = r_we & ~reset;  // a reset landing on a write cycle cancels the write
    end
  end

  // Capture registers double as the RAM drive, so they hold their value through IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_b <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_any) begin
      r_last_b <= w_win_b;
      r_we     <= w_win_b ? b_we    : a_we;
      r_addr   <= w_win_b ? b_addr  : a_addr;
      r_wdata  <= w_win_b ? b_wdata : a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if (r_state == S_ACCESS && !r_we) begin
        if (r_last_b) begin
          r_b_rvalid <= 1'b1;
          r_b_rdata  <= ram_q;
        end else begin
          r_a_rvalid <= 1'b1;
          r_a_rdata  <= ram_q;
        end
      end
    end
  end

  assign ram_addr = r_addr;
  assign ram_d    = r_wdata;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 4096x16 RAM model attached.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [11:0] ram_addr;
  logic        ram_load;
  logic [15:0] ram_d, ram_q;
  logic        busy;

  logic [15:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DW(16), .AW(12)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_load(ram_load), .ram_d(ram_d), .ram_q(ram_q),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_q = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
    mem[12'h010] <= 16'h1234;
    mem[12'h030] <= 16'h5A5A;
    mem[12'h400] <= 16'h7777;
    mem[12'h000] <= 16'h1111;
    mem[12'h001] <= 16'h2222;
    mem[12'h002] <= 16'h3333;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    tick(); tick();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_load", ram_load, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    reset = 1'b0;
    tick();

    // Single A read of 0x010
    a_req = 1; a_we = 0; a_addr = 12'h010;
    tick();
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_b_gnt", b_gnt, 0);
    chk("rd_busy", busy, 1);
    chk("rd_ram_addr", ram_addr, 12'h010);
    chk("rd_ram_load", ram_load, 0);
    a_req = 0;
    tick();
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 16'h1234);
    chk("rd_b_rvalid", b_rvalid, 0);
    chk("rd_gnt_gone", a_gnt, 0);
    chk("rd_idle_busy", busy, 0);

    // B writes 0xABCD to 0x0FF, then A reads it back
    b_req = 1; b_we = 1; b_addr = 12'h0FF; b_wdata = 16'hABCD;
    tick();
    chk("bw_b_gnt", b_gnt, 1);
    chk("bw_ram_load", ram_load, 1);
    chk("bw_ram_addr", ram_addr, 12'h0FF);
    chk("bw_ram_d", ram_d, 16'hABCD);
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_addr = 12'h0FF;
    tick();
    chk("ar_a_gnt", a_gnt, 1);
    chk("ar_ram_load", ram_load, 0);
    chk("bw_no_rvalid", b_rvalid, 0);
    a_req = 0;
    tick();
    chk("ar_a_rvalid", a_rvalid, 1);
    chk("ar_a_rdata", a_rdata, 16'hABCD);
    chk("ar_b_rdata", b_rdata, 0);
    chk("ar_idle_load", ram_load, 0);
    chk("ar_idle_addr_hold", ram_addr, 12'h0FF);

    // Reset landing on B's write grant
    b_req = 1; b_we = 1; b_addr = 12'h400; b_wdata = 16'hBEEF;
    tick();
    chk("rw_b_gnt", b_gnt, 1);
    reset = 1; b_req = 0; b_we = 0;
    #1;
    chk("rw_load_suppressed", ram_load, 0);
    tick();
    chk("rw_mem_kept", mem[12'h400], 16'h7777);
    chk("rw_busy", busy, 0);
    chk("rw_b_gnt_after", b_gnt, 0);
    chk("rw_b_rvalid", b_rvalid, 0);
    chk("rw_a_rdata", a_rdata, 0);
    chk("rw_ram_addr", ram_addr, 0);
    chk("rw_ram_d", ram_d, 0);
    reset = 0;
    tick();

    // Both ports requesting reads
    a_req = 1; a_we = 0; a_addr = 12'h020;
    b_req = 1; b_we = 0; b_addr = 12'h030;
`ifdef ARB_RR_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_a_gnt_%0d", i), a_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_b_gnt_%0d", i), b_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_busy_%0d", i), busy, 1);
      if (i == 6) a_req = 0;
      if (i == 7) b_req = 0;
    end
    tick();
    chk("rr_end_busy", busy, 0);
    chk("rr_b_rdata", b_rdata, 16'h5A5A);
`else
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("fp_a_gnt_%0d", i), a_gnt, 1);
      chk($sformatf("fp_b_gnt_%0d", i), b_gnt, 0);
      chk($sformatf("fp_busy_%0d", i), busy, 1);
      if (i == 4) a_req = 0;
    end
    tick();
    chk("fp_b_gnt_late", b_gnt, 1);
    chk("fp_a_gnt_late", a_gnt, 0);
    b_req = 0;
    tick();
    chk("fp_b_rvalid", b_rvalid, 1);
    chk("fp_b_rdata", b_rdata, 16'h5A5A);
`endif
    tick();

    // Back-to-back A reads of 0x000..0x002
    a_req = 1; a_we = 0; a_addr = 12'h000;
    tick();
    chk("bb_gnt0", a_gnt, 1);
    a_addr = 12'h001;
    tick();
    chk("bb_gnt1", a_gnt, 1);
    chk("bb_rv0", a_rvalid, 1);
    chk("bb_rd0", a_rdata, 16'h1111);
    a_addr = 12'h002;
    tick();
    chk("bb_gnt2", a_gnt, 1);
    chk("bb_rv1", a_rvalid, 1);
    chk("bb_rd1", a_rdata, 16'h2222);
    a_req = 0;
    tick();
    chk("bb_gnt_end", a_gnt, 0);
    chk("bb_rv2", a_rvalid, 1);
    chk("bb_rd2", a_rdata, 16'h3333);
    tick();
    chk("bb_rv_end", a_rvalid, 0);
    chk("bb_rd_hold", a_rdata, 16'h3333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single 4096x16 program/data RAM between the CPU core (port A) and a host loader/debug master (port B). It accepts one request per cycle from either port, picks a winner, drives the RAM address, write-enable and data lines from registered copies of the winning request, and returns read data with a fixed latency. It sits between the CPU's memory port and the `ram` instance, so the host can load or inspect memory while the core runs.

## Interface
- `DW`, 16, data width (RAM word)
- `AW`, 12, address width (4096 words)

- `clk`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `a_req`  in  1  port A (CPU) request, held until `a_gnt`
- `a_we`  in  1  port A write (1) / read (0)
- `a_addr`  in  AW  port A address
- `a_wdata`  in  DW  port A write data
- `a_gnt`  out  1  one-cycle grant pulse; access performed in this cycle
- `a_rvalid`  out  1  one-cycle pulse, `a_rdata` holds new read data
- `a_rdata`  out  DW  port A read data, held until the next port A read
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as port A, for the host
- `ram_addr`  out  AW  RAM address
- `ram_load`  out  1  RAM write enable (write on rising edge)
- `ram_d`  out  DW  RAM write data
- `ram_q`  in  DW  RAM read data, combinational from `ram_addr`
- `busy`  out  1  high in every ACCESS cycle

## Operation
- States: IDLE, ACCESS.
- Each cycle the arbiter samples `a_req`/`b_req`. If either is high it picks a winner per the arbitration rule below and latches `we`/`addr`/`wdata` into capture registers. Next state is ACCESS and the winner's `gnt` goes high next cycle. If neither is high, next state is IDLE.
- In ACCESS, `ram_addr`/`ram_d` come from the capture registers and `ram_load` = captured `we`. Requests are sampled in the same cycle, so back-to-back accesses run at one per cycle.
- A `req` that is high in a cycle where that port's `gnt` is high counts as a new request. A requester doing a single access must drop `req` during its `gnt` cycle.
- Reads: at the end of ACCESS, `ram_q` is captured into the winner's `rdata`, and that port's `rvalid` pulses next cycle. Writes produce no `rvalid`. `rdata` of the other port is unchanged.
- Arbitration: if only one port requests, it wins. If both request, the outcome depends on `ARB_RR_EN` (see Configuration). The register `last` records the most recent winner.
- The losing request stays pending, since the port holds `req`, and is granted in the following cycle unless it loses again.
- In IDLE: `ram_load` = 0, and `ram_addr`/`ram_d` hold their last values.

## Timing
- Reset values: `a_gnt` = `b_gnt` = 0, `a_rvalid` = `b_rvalid` = 0, `a_rdata` = `b_rdata` = 0, `ram_load` = 0, `ram_addr` = 0, `ram_d` = 0, `busy` = 0, state IDLE, `last` = B.
- Latency:
  - `req` sampled in cycle T, with the port winning.
  - `gnt` and RAM access in T+1.
  - `rvalid`/`rdata` in T+2.
- Sustained throughput: one access per cycle. `busy` stays high across back-to-back grants.
- Both ports requesting in T: the winner is granted in T+1 and the loser in T+2, provided the winner dropped `req` in T+1.
- Reset asserted in an ACCESS cycle: the write is suppressed (`ram_load` forced 0), no `rvalid` follows, and the captured request is discarded. Requesters must re-issue after reset.
- Address wrap: none. `addr` is used as-is, and all AW bits are valid.

## Configuration
- `ARB_RR_EN` defined: round-robin. On a tie the port that is not `last` wins, so after reset A wins the first tie. Neither port can be starved; each waits at most one grant.
- `ARB_RR_EN` undefined: fixed priority. A (CPU) always wins ties, and B can be starved while `a_req` stays high. `last` is still maintained but is not used for the decision.

## Test plan
- Single A read: preload RAM[0x010] = 16'h1234, `a_req` = 1, `a_we` = 0, `a_addr` = 0x010 in T, dropped in T+1. Expect `a_gnt` = 1 in T+1, `a_rvalid` = 1 and `a_rdata` = 16'h1234 in T+2, `b_*` quiet.
- B write then A read of the same address: B writes 0xABCD to 0x0FF, then A reads 0x0FF. Expect `ram_load` = 1 only in B's grant cycle, and `a_rdata` = 0xABCD.
- Simultaneous requests with `ARB_RR_EN`: both ports hold `req` for 4 accesses each. Expect grants alternating A,B,A,B,… starting with A, `busy` high continuously, and 8 grants total.
- Simultaneous requests without `ARB_RR_EN`: A holds `req` for 5 cycles while B is requesting. Expect 5 consecutive `a_gnt`, then `b_gnt` in the cycle after A drops `req`.
- Reset in mid-write: B write granted, `reset` = 1 during ACCESS. Expect `ram_load` = 0, target word unchanged, all outputs at reset values next cycle.
- Back-to-back reads from A at 0x000, 0x001, 0x002 on consecutive cycles. Expect `a_rvalid` high for 3 consecutive cycles with the matching data in order.
